// File: rtl/tdm_demux_deser.sv
// Receive side of a 2:1 bit-level TDM link: steers each sampled bit to channel A or B,
// deserializes MSB first, and hands out whole words over valid/ready with sticky overflow.
module tdm_demux_deser #(
   parameter int WIDTH = 8
) (
   input  logic             Clk_in,
   input  logic             Rst_n_in,
   input  logic             Sample_in,
   input  logic             Select_in,
   input  logic             Y_in,
   input  logic             Sync_in,
   output logic [WIDTH-1:0] A_data_out,
   output logic             A_valid_out,
   input  logic             A_ready_in,
   output logic             A_ovf_out,
   output logic [WIDTH-1:0] B_data_out,
   output logic             B_valid_out,
   input  logic             B_ready_in,
   output logic             B_ovf_out
);

   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   logic [2*WIDTH-1:0] data_w;
   logic [1:0]         vld_w;
   logic [1:0]         ovf_w;

   for (genvar c = 0; c < 2; c++) begin : g_ch
      logic             sample;
      logic             ready;
      logic             complete;
      logic             drain;
      logic [WIDTH-1:0] sh_q, sh_d;
      logic [WIDTH-1:0] hold_q, hold_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             ovf_q, ovf_d;
      state_t           state_q, state_d;

      assign sample = Sample_in && (Select_in == 1'(c));
      assign ready  = (c == 0) ? A_ready_in : B_ready_in;

      always_comb begin
         // Sync realigns first so a same-cycle sample lands as bit 0 of the new word.
         sh_d     = Sync_in ? '0 : sh_q;
         cnt_d    = Sync_in ? '0 : cnt_q;
         complete = 1'b0;
         if (sample) begin
            complete = (cnt_d == CNT_W'(WIDTH - 1));
            sh_d     = {sh_d[WIDTH-2:0], Y_in};
            cnt_d    = complete ? '0 : cnt_d + CNT_W'(1);
         end

         drain   = (state_q == FULL) && ready;
         state_d = state_q;
         hold_d  = hold_q;
         ovf_d   = ovf_q;
         if (complete) begin
            // A draining holding register frees its slot on the very edge the new word arrives.
            if ((state_q == EMPTY) || drain) begin
               hold_d  = sh_d;
               state_d = FULL;
            end else begin
               ovf_d = 1'b1;
            end
         end else if (drain) begin
            state_d = EMPTY;
         end
      end

      always_ff @(posedge Clk_in or negedge Rst_n_in) begin
         if (!Rst_n_in) begin
            sh_q    <= '0;
            cnt_q   <= '0;
            hold_q  <= '0;
            ovf_q   <= 1'b0;
            state_q <= EMPTY;
         end else begin
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            ovf_q   <= ovf_d;
            state_q <= state_d;
         end
      end

      assign data_w[c*WIDTH +: WIDTH] = hold_q;
      assign vld_w[c]                 = (state_q == FULL);
      assign ovf_w[c]                 = ovf_q;
   end

   assign A_data_out  = data_w[WIDTH-1:0];
   assign B_data_out  = data_w[2*WIDTH-1:WIDTH];
   assign A_valid_out = vld_w[0];
   assign B_valid_out = vld_w[1];
   assign A_ovf_out   = ovf_w[0];
   assign B_ovf_out   = ovf_w[1];

endmodule

// File: tb/tb_tdm_demux_deser.sv
// Bench for tdm_demux_deser: word-level reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_tdm_demux_deser;

   localparam int W = 8;

   logic         Clk_in, Rst_n_in;
   logic         Sample_in, Select_in, Y_in, Sync_in;
   logic [W-1:0] A_data_out, B_data_out;
   logic         A_valid_out, B_valid_out, A_ovf_out, B_ovf_out;
   logic         A_ready_in, B_ready_in;

   int checks   = 0;
   int failures = 0;

   // Reference model state per channel: bits collected since the last word boundary.
   int           m_nbits [2];
   logic [W-1:0] m_acc   [2];
   logic [W-1:0] m_hold  [2];
   logic         m_vld   [2];
   logic         m_ovf   [2];

   tdm_demux_deser #(.WIDTH(W)) dut (
      .Clk_in(Clk_in), .Rst_n_in(Rst_n_in),
      .Sample_in(Sample_in), .Select_in(Select_in), .Y_in(Y_in), .Sync_in(Sync_in),
      .A_data_out(A_data_out), .A_valid_out(A_valid_out),
      .A_ready_in(A_ready_in), .A_ovf_out(A_ovf_out),
      .B_data_out(B_data_out), .B_valid_out(B_valid_out),
      .B_ready_in(B_ready_in), .B_ovf_out(B_ovf_out)
   );

   initial begin
      Clk_in = 1'b0;
      forever #5 Clk_in = ~Clk_in;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < 2; c++) begin
         m_nbits[c] = 0;
         m_acc[c]   = '0;
         m_hold[c]  = '0;
         m_vld[c]   = 1'b0;
         m_ovf[c]   = 1'b0;
      end
   endtask

   task automatic model_step();
      logic         smp, rdy, done, take;
      logic [W-1:0] word;
      for (int c = 0; c < 2; c++) begin
         smp  = Sample_in && (Select_in == (c == 1));
         rdy  = (c == 0) ? A_ready_in : B_ready_in;
         done = 1'b0;
         word = '0;
         if (Sync_in) begin
            m_nbits[c] = 0;
            m_acc[c]   = '0;
         end
         if (smp) begin
            m_acc[c]   = {m_acc[c][W-2:0], Y_in};
            m_nbits[c] = m_nbits[c] + 1;
            if (m_nbits[c] == W) begin
               done       = 1'b1;
               word       = m_acc[c];
               m_nbits[c] = 0;
            end
         end
         take = m_vld[c] && rdy;
         if (done) begin
            if (!m_vld[c] || take) begin
               m_hold[c] = word;
               m_vld[c]  = 1'b1;
            end else begin
               m_ovf[c] = 1'b1;
            end
         end else if (take) begin
            m_vld[c] = 1'b0;
         end
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge Clk_in or negedge Rst_n_in);
         if (!Rst_n_in) model_reset();
         else model_step();
      end
   end

   // Every cycle: outputs must equal the model, sampled mid-cycle.
   initial begin
      forever begin
         @(negedge Clk_in);
         chk("cmp_A_valid", 32'(A_valid_out), 32'(m_vld[0]));
         chk("cmp_B_valid", 32'(B_valid_out), 32'(m_vld[1]));
         chk("cmp_A_ovf",   32'(A_ovf_out),   32'(m_ovf[0]));
         chk("cmp_B_ovf",   32'(B_ovf_out),   32'(m_ovf[1]));
         chk("cmp_A_data",  32'(A_data_out),  32'(m_hold[0]));
         chk("cmp_B_data",  32'(B_data_out),  32'(m_hold[1]));
      end
   end

   task automatic send(input logic ch, input logic b);
      Sample_in = 1'b1;
      Select_in = ch;
      Y_in      = b;
      @(posedge Clk_in);
      #1;
      Sample_in = 1'b0;
   endtask

   task automatic send_word(input logic ch, input logic [W-1:0] w);
      for (int i = W - 1; i >= 0; i--) send(ch, w[i]);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge Clk_in);
         #1;
      end
   endtask

   task automatic pulse_reset();
      @(posedge Clk_in);
      #3 Rst_n_in = 1'b0;
      #4 Rst_n_in = 1'b1;
      @(posedge Clk_in);
      #1;
   endtask

   task automatic chk_all_zero(input string nm);
      chk(nm, {A_data_out, B_data_out, 12'h0, A_valid_out, B_valid_out, A_ovf_out, B_ovf_out}, 32'h0);
   endtask

   initial begin
      logic [W-1:0] wa, wb;
      Rst_n_in   = 1'b0;
      Sample_in  = 1'b0;
      Select_in  = 1'b0;
      Y_in       = 1'b0;
      Sync_in    = 1'b0;
      A_ready_in = 1'b0;
      B_ready_in = 1'b0;

      // Reset held while inputs toggle.
      for (int i = 0; i < 12; i++) begin
         @(posedge Clk_in);
         #1;
         Sample_in  = 1'b1;
         Select_in  = i[1];
         Y_in       = i[0];
         Sync_in    = (i == 5);
         A_ready_in = i[2];
      end
      chk_all_zero("reset_held");
      Sample_in = 1'b0;
      Sync_in   = 1'b0;
      A_ready_in = 1'b1;
      B_ready_in = 1'b1;
      @(posedge Clk_in);
      #3 Rst_n_in = 1'b1;
      idle(2);
      chk_all_zero("reset_release");

      // Single channel word.
      send_word(1'b0, 8'hA5);
      chk("single_A_valid", 32'(A_valid_out), 32'd1);
      chk("single_A_data", 32'(A_data_out), 32'hA5);
      chk("single_B_valid", 32'(B_valid_out), 32'd0);
      idle(1);
      chk("single_A_drained", 32'(A_valid_out), 32'd0);

      // Interleaved channels.
      wa = 8'h3C;
      wb = 8'hC3;
      for (int i = W - 1; i >= 0; i--) begin
         send(1'b0, wa[i]);
         if (i == 0) begin
            chk("ilv_A_valid", 32'(A_valid_out), 32'd1);
            chk("ilv_A_data", 32'(A_data_out), 32'h3C);
         end
         send(1'b1, wb[i]);
      end
      chk("ilv_B_valid", 32'(B_valid_out), 32'd1);
      chk("ilv_B_data", 32'(B_data_out), 32'hC3);
      chk("ilv_no_ovf", {30'h0, A_ovf_out, B_ovf_out}, 32'h0);
      idle(1);

      // Backpressure and overflow.
      A_ready_in = 1'b0;
      send_word(1'b0, 8'h11);
      chk("bp_first_valid", 32'(A_valid_out), 32'd1);
      chk("bp_first_data", 32'(A_data_out), 32'h11);
      send_word(1'b0, 8'h22);
      chk("bp_held_data", 32'(A_data_out), 32'h11);
      chk("bp_ovf_set", 32'(A_ovf_out), 32'd1);
      A_ready_in = 1'b1;
      idle(1);
      A_ready_in = 1'b0;
      chk("bp_drained", 32'(A_valid_out), 32'd0);
      chk("bp_ovf_sticky", 32'(A_ovf_out), 32'd1);
      idle(2);

      // Drain and complete on the same edge.
      pulse_reset();
      chk("rst_clears_ovf", 32'(A_ovf_out), 32'd0);
      send_word(1'b0, 8'h11);
      wa = 8'h77;
      for (int i = W - 1; i >= 1; i--) send(1'b0, wa[i]);
      A_ready_in = 1'b1;
      send(1'b0, wa[0]);
      A_ready_in = 1'b0;
      chk("dc_valid", 32'(A_valid_out), 32'd1);
      chk("dc_data", 32'(A_data_out), 32'h77);
      chk("dc_no_ovf", 32'(A_ovf_out), 32'd0);
      A_ready_in = 1'b1;
      idle(1);
      chk("dc_drained", 32'(A_valid_out), 32'd0);

      // Sync mid-word on both channels.
      B_ready_in = 1'b1;
      send(1'b0, 1'b1);
      send(1'b0, 1'b0);
      send(1'b0, 1'b1);
      send(1'b1, 1'b1);
      send(1'b1, 1'b1);
      wa = 8'hF0;
      Sync_in = 1'b1;
      send(1'b0, wa[7]);
      Sync_in = 1'b0;
      for (int i = W - 2; i >= 0; i--) send(1'b0, wa[i]);
      chk("sync_A_valid", 32'(A_valid_out), 32'd1);
      chk("sync_A_data", 32'(A_data_out), 32'hF0);
      send_word(1'b1, 8'h96);
      chk("sync_B_valid", 32'(B_valid_out), 32'd1);
      chk("sync_B_data", 32'(B_data_out), 32'h96);
      idle(1);

      // Reset mid-word discards the partial word.
      wa = 8'hFF;
      for (int i = 0; i < 4; i++) send(1'b0, wa[i]);
      pulse_reset();
      chk_all_zero("rst_mid_word");
      idle(3);
      chk("rst_mid_no_word", 32'(A_valid_out), 32'd0);
      send_word(1'b0, 8'h5A);
      chk("rst_mid_next_valid", 32'(A_valid_out), 32'd1);
      chk("rst_mid_next_data", 32'(A_data_out), 32'h5A);

      // Mixed traffic with irregular readies and occasional sync; model checks every cycle.
      for (int i = 0; i < 160; i++) begin
         A_ready_in = (i % 3) != 0;
         B_ready_in = (i % 7) < 2;
         Sync_in    = (i == 53) || (i == 111);
         wa         = 8'(i * 37 + 11);
         if ((i % 4) == 3) idle(1);
         else send(wa[3], wa[5] ^ wa[0]);
      end
      Sync_in    = 1'b0;
      A_ready_in = 1'b1;
      B_ready_in = 1'b1;
      idle(3);
      chk("final_A_valid", 32'(A_valid_out), 32'd0);
      chk("final_B_valid", 32'(B_valid_out), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tdm_demux_deser.md
# tdm_demux_deser

Receive-side stage that consumes the single-bit time-multiplexed line produced by the 2:1 multiplexer and its select signal. Each sampled bit is steered back to its source channel (A or B), shifted into a per-channel deserializer, and presented as a parallel word behind a valid/ready handshake. A sticky overflow flag per channel records words dropped under backpressure.

## Interface
- WIDTH, 8, word length in bits per channel (min 2)
- Clk_in  input  1  system clock, all state on rising edge
- Rst_n_in  input  1  asynchronous, active-low reset
- Sample_in  input  1  qualifies Y_in/Select_in this cycle
- Select_in  input  1  channel of current bit: 0 = A, 1 = B
- Y_in  input  1  multiplexed data bit
- Sync_in  input  1  word-boundary realign, both channels
- A_data_out  output  WIDTH  channel A word
- A_valid_out  output  1  A_data_out holds an unconsumed word
- A_ready_in  input  1  consumer accepts A word
- A_ovf_out  output  1  sticky: A word dropped
- B_data_out, B_valid_out, B_ready_in, B_ovf_out: same as A, channel B

## Operation
- Per channel: shift register sh (WIDTH), bit counter cnt (0..WIDTH-1), holding register + valid flag (state EMPTY/FULL), ovf flag.
- Sample_in=1: channel ch = Select_in; sh_ch <= {sh_ch[WIDTH-2:0], Y_in} (MSB first); other channel untouched.
- cnt_ch == WIDTH-1 on a sample: word complete = {sh_ch[WIDTH-2:0], Y_in}; cnt_ch wraps to 0.
- Complete word transfer: if EMPTY, or FULL with valid&ready this edge -> holding <= word, state FULL. Else (FULL, not ready) -> word dropped, holding unchanged, ovf_ch <= 1.
- FULL -> EMPTY on edge with valid&ready and no word completing.
- Sync_in=1: both cnt and sh cleared; a sample in the same cycle is taken as bit 0 of the new word (cnt_ch -> 1). Holding registers, valid, ovf unaffected.
- Sample_in=0: Select_in, Y_in ignored; counters hold.
- ovf cleared only by reset.

## Timing
- Reset (async assert, sync release): all data outputs 0, all valid 0, all ovf 0, cnt 0, sh 0.
- Reset mid-word discards partial words; mid-handshake drops held word.
- Latency: valid_out and data_out update on the same edge that samples the last bit (visible next cycle).
- data_out stable while valid_out=1 and ready_in=0.
- ready_in with valid_out=0 has no effect.
- Both channels may complete and/or drain on the same edge independently.
- Throughput: one word per channel per WIDTH samples of that channel; no bubbles with ready_in held 1.

## Test plan
- Reset: hold Rst_n_in=0, toggle inputs -> all outputs 0; deassert mid-cycle -> still 0 until samples arrive.
- Single channel: A_ready_in=1, Select_in=0, 8 samples of 0xA5 MSB first -> A_valid_out high one cycle, A_data_out=0xA5; B_valid_out stays 0.
- Interleaved: Select alternates 0/1 each sample, A bits of 0x3C, B bits of 0xC3, 16 samples -> A valid with 0x3C after 15th sample, B valid with 0xC3 after 16th; no ovf.
- Backpressure: A_ready_in=0, send 0x11 then 0x22 -> A_data_out stays 0x11, A_ovf_out=1 after 0x22's last bit; raise ready one cycle -> valid drops, ovf stays 1.
- Drain+complete same edge: A holds 0x11, ready=1 asserted exactly on edge completing 0x77 -> valid stays 1, data becomes 0x77, ovf stays 0.
- Sync/reset mid-word: 3 A bits sent, then Sync_in with sample of bit 1, then 7 more bits forming 0xF0 -> A_data_out=0xF0; separately pull Rst_n_in low after 4 bits -> no word emitted, next 8 bits 0x5A yield 0x5A.
